camara_captura: RTL and testbench

- Parametrised, single-clock successor of the camera capture front end.
- Drives Xclk, Reset and PWDN to the sensor.
- Samples Pclk/Href/Vsync/Imagen in the clk domain, assembles bytes into pixels in a runtime-selectable format, and emits framebuffer write strobes with linear addresses.
- Reports per-frame completion and error status to the controller.

---
 rtl/camara_captura.sv | 273 +++++++++++++++++++++++++++
 tb/tb_camara_captura.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/camara_captura.sv
// Camera capture front end: drives Xclk/Reset/PWDN to the sensor, samples the
// sensor bus in the clk domain and turns it into linear framebuffer writes.
module camara_captura #(
  parameter int unsigned H_PIX       = 160,
  parameter int unsigned V_LIN       = 120,
  parameter int unsigned XCLK_DIV    = 2,
  parameter int unsigned RST_CYC     = 16,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned ADDR_W      = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              Vsync,
  input  logic              Href,
  input  logic              Pclk,
  input  logic [7:0]        Imagen,
  input  logic [1:0]        modo,
  input  logic              captura_en,
  input  logic              pwdn_req,
  output logic              Xclk,
  output logic              Reset,
  output logic              PWDN,
  output logic              px_valid,
  output logic [ADDR_W-1:0] px_addr,
  output logic [15:0]       px_data,
  output logic              frame_done,
  output logic              frame_ok,
  output logic              ocupado
);

  localparam int unsigned XHALF = XCLK_DIV / 2;
  localparam int unsigned XCW   = $clog2(XHALF + 1);
  localparam int unsigned RCW   = $clog2(RST_CYC + 1);
  localparam int unsigned COLW  = $clog2(H_PIX + 1);
  localparam int unsigned LINW  = $clog2(V_LIN + 2);
  localparam int unsigned LAST  = SYNC_STAGES - 1;

  typedef enum logic [1:0] {ESPERA, SINC, CAPTURA} estado_t;

  // Sensor control outputs
  logic [XCW-1:0] xcnt_q;
  logic           xclk_q;
  logic [RCW-1:0] rcnt_q;
  logic           reset_q;
  logic           pwdn_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      xcnt_q  <= '0;
      xclk_q  <= 1'b0;
      rcnt_q  <= '0;
      reset_q <= 1'b0;
      pwdn_q  <= 1'b0;
    end else begin
      pwdn_q <= pwdn_req;
      if (xcnt_q == XCW'(XHALF - 1)) begin
        xcnt_q <= '0;
        xclk_q <= ~xclk_q;
      end else begin
        xcnt_q <= xcnt_q + XCW'(1);
      end
      if (!reset_q) begin
        if (rcnt_q == RCW'(RST_CYC - 1)) reset_q <= 1'b1;
        rcnt_q <= rcnt_q + RCW'(1);
      end
    end
  end

  // Input synchronisers plus one extra sample of the 1-bit strobes for edges
  logic [SYNC_STAGES-1:0] pclk_sr, href_sr, vsync_sr;
  logic [7:0]             img_sr [SYNC_STAGES];
  logic                   pclk_prev_q, href_prev_q, vsync_prev_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      pclk_sr      <= '0;
      href_sr      <= '0;
      vsync_sr     <= '0;
      pclk_prev_q  <= 1'b0;
      href_prev_q  <= 1'b0;
      vsync_prev_q <= 1'b0;
      for (int unsigned i = 0; i < SYNC_STAGES; i++) img_sr[i] <= 8'h00;
    end else begin
      pclk_sr[0]  <= Pclk;
      href_sr[0]  <= Href;
      vsync_sr[0] <= Vsync;
      img_sr[0]   <= Imagen;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
        pclk_sr[i]  <= pclk_sr[i-1];
        href_sr[i]  <= href_sr[i-1];
        vsync_sr[i] <= vsync_sr[i-1];
        img_sr[i]   <= img_sr[i-1];
      end
      pclk_prev_q  <= pclk_sr[LAST];
      href_prev_q  <= href_sr[LAST];
      vsync_prev_q <= vsync_sr[LAST];
    end
  end

  logic       pclk_rise, href_s, href_fall, vs_rise, vs_fall;
  logic [7:0] img_s;

  assign img_s     = img_sr[LAST];
  assign href_s    = href_sr[LAST];
  assign pclk_rise = pclk_sr[LAST] & ~pclk_prev_q;
  assign href_fall = ~href_s & href_prev_q;
  assign vs_rise   = vsync_sr[LAST] & ~vsync_prev_q;
  assign vs_fall   = ~vsync_sr[LAST] & vsync_prev_q;

  // Capture state
  estado_t           state_q, state_d;
  logic [1:0]        modo_q, modo_d;
  logic [7:0]        hi_q, hi_d;
  logic              fase_q, fase_d;
  logic [COLW-1:0]   col_q, col_d;
  logic [LINW-1:0]   lin_q, lin_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic              line_bad_q, line_bad_d;
  logic              frame_bad_q, frame_bad_d;
  logic              px_valid_q, px_valid_d;
  logic [ADDR_W-1:0] px_addr_q, px_addr_d;
  logic [15:0]       px_data_q, px_data_d;
  logic              frame_done_q, frame_done_d;
  logic              frame_ok_q, frame_ok_d;
  logic              ocupado_q, ocupado_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ESPERA;
      modo_q       <= 2'b00;
      hi_q         <= 8'h00;
      fase_q       <= 1'b0;
      col_q        <= '0;
      lin_q        <= '0;
      base_q       <= '0;
      line_bad_q   <= 1'b0;
      frame_bad_q  <= 1'b0;
      px_valid_q   <= 1'b0;
      px_addr_q    <= '0;
      px_data_q    <= 16'h0000;
      frame_done_q <= 1'b0;
      frame_ok_q   <= 1'b0;
      ocupado_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      modo_q       <= modo_d;
      hi_q         <= hi_d;
      fase_q       <= fase_d;
      col_q        <= col_d;
      lin_q        <= lin_d;
      base_q       <= base_d;
      line_bad_q   <= line_bad_d;
      frame_bad_q  <= frame_bad_d;
      px_valid_q   <= px_valid_d;
      px_addr_q    <= px_addr_d;
      px_data_q    <= px_data_d;
      frame_done_q <= frame_done_d;
      frame_ok_q   <= frame_ok_d;
      ocupado_q    <= ocupado_d;
    end
  end

  logic        emit;
  logic [15:0] word;
  logic [15:0] pix;

  // Next-state, byte assembly, line/frame bookkeeping
  always_comb begin
    state_d      = state_q;
    modo_d       = modo_q;
    hi_d         = hi_q;
    fase_d       = fase_q;
    col_d        = col_q;
    lin_d        = lin_q;
    base_d       = base_q;
    line_bad_d   = line_bad_q;
    frame_bad_d  = frame_bad_q;
    px_valid_d   = 1'b0;
    px_addr_d    = px_addr_q;
    px_data_d    = px_data_q;
    frame_done_d = 1'b0;
    frame_ok_d   = frame_ok_q;
    emit         = 1'b0;
    word         = 16'h0000;
    pix          = 16'h0000;

    case (state_q)
      ESPERA: begin
        if (vs_rise) state_d = SINC;
      end
      SINC: begin
        if (vs_fall) begin
          if (captura_en && !pwdn_q) begin
            state_d     = CAPTURA;
            modo_d      = modo;
            fase_d      = 1'b0;
            col_d       = '0;
            lin_d       = '0;
            base_d      = '0;
            line_bad_d  = 1'b0;
            frame_bad_d = 1'b0;
          end else begin
            state_d = ESPERA;
          end
        end
      end
      CAPTURA: begin
        if (pclk_rise && href_s) begin
          if (!modo_q[1]) begin
            if (!fase_q) begin
              hi_d   = img_s;
              fase_d = 1'b1;
            end else begin
              fase_d = 1'b0;
              emit   = 1'b1;
              word   = {hi_q, img_s};
            end
          end else begin
            emit = 1'b1;
            word = {8'h00, img_s};
          end
          pix = (modo_q == 2'b01) ? {8'h00, word[15:13], word[10:8], word[4:3]} : word;
          if (emit) begin
            if (col_q >= COLW'(H_PIX)) begin
              line_bad_d = 1'b1;
            end else if (lin_q >= LINW'(V_LIN)) begin
              frame_bad_d = 1'b1;
            end else begin
              px_valid_d = 1'b1;
              px_addr_d  = base_q + ADDR_W'(col_q);
              px_data_d  = pix;
            end
            if (col_q < COLW'(H_PIX)) col_d = col_q + COLW'(1);
          end
        end
        // Line close happens before the frame close below, so a coincident
        // Vsync rise sees the final line already counted.
        if (href_fall) begin
          col_d      = '0;
          fase_d     = 1'b0;
          line_bad_d = 1'b0;
          if ((!modo_q[1] && fase_q) || line_bad_q ||
              (col_q != '0 && col_q != COLW'(H_PIX)))
            frame_bad_d = 1'b1;
          if (col_q != '0) begin
            if (lin_q <= LINW'(V_LIN)) lin_d = lin_q + LINW'(1);
            if (lin_q < LINW'(V_LIN)) base_d = base_q + ADDR_W'(H_PIX);
          end
        end
        if (vs_rise) begin
          state_d      = ESPERA;
          frame_done_d = 1'b1;
          frame_ok_d   = (lin_d == LINW'(V_LIN)) && !frame_bad_d &&
                         (col_d == '0) && !fase_d && !line_bad_d;
        end
      end
      default: state_d = ESPERA;
    endcase

    ocupado_d = (state_d == CAPTURA);
  end

  assign Xclk       = xclk_q;
  assign Reset      = reset_q;
  assign PWDN       = pwdn_q;
  assign px_valid   = px_valid_q;
  assign px_addr    = px_addr_q;
  assign px_data    = px_data_q;
  assign frame_done = frame_done_q;
  assign frame_ok   = frame_ok_q;
  assign ocupado    = ocupado_q;

endmodule

// File: tb/tb_camara_captura.sv
// Self-checking bench for camara_captura: directed and random frames compared
// against a frame-level reference model of the expected writes and status.
module tb_camara_captura;

  localparam int unsigned H  = 4;
  localparam int unsigned V  = 2;
  localparam int unsigned AW = 3;

  logic          clk = 1'b0;
  logic          rst, Vsync, Href, Pclk, captura_en, pwdn_req;
  logic [7:0]    Imagen;
  logic [1:0]    modo;
  logic          Xclk, Reset, PWDN, px_valid, frame_done, frame_ok, ocupado;
  logic [AW-1:0] px_addr;
  logic [15:0]   px_data;

  camara_captura #(
    .H_PIX(H), .V_LIN(V), .XCLK_DIV(2), .RST_CYC(16), .SYNC_STAGES(2), .ADDR_W(AW)
  ) dut (
    .clk(clk), .rst(rst), .Vsync(Vsync), .Href(Href), .Pclk(Pclk),
    .Imagen(Imagen), .modo(modo), .captura_en(captura_en), .pwdn_req(pwdn_req),
    .Xclk(Xclk), .Reset(Reset), .PWDN(PWDN), .px_valid(px_valid),
    .px_addr(px_addr), .px_data(px_data), .frame_done(frame_done),
    .frame_ok(frame_ok), .ocupado(ocupado)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Observed traffic
  logic [AW-1:0] obs_addr[$];
  logic [15:0]   obs_data[$];
  int            done_cnt;
  logic          last_ok;
  logic          ocup_seen;

  always @(negedge clk) begin
    if (px_valid) begin
      obs_addr.push_back(px_addr);
      obs_data.push_back(px_data);
    end
    if (frame_done) begin
      done_cnt++;
      last_ok = frame_ok;
    end
    if (ocupado) ocup_seen = 1'b1;
  end

  // Stimulus description of one frame and the model's expectations
  logic [7:0]  bq[$];
  int          ln[$];
  int          exp_addr[$];
  logic [15:0] exp_data[$];
  logic        exp_ok;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Frame-level reference: pixels per line from byte counts, linear addresses
  task automatic model(input logic [1:0] m);
    int idx, lin, n, npix;
    bit ok, odd;
    logic [15:0] w;
    idx = 0; lin = 0; ok = 1'b1;
    exp_addr.delete();
    exp_data.delete();
    foreach (ln[l]) begin
      n = ln[l];
      npix = m[1] ? n : n / 2;
      odd  = m[1] ? 1'b0 : bit'(n % 2);
      for (int p = 0; p < npix; p++) begin
        if (m[1]) w = {8'h00, bq[idx+p]};
        else      w = {bq[idx+2*p], bq[idx+2*p+1]};
        if (m == 2'b01)
          w = 16'((w >> 13) * 32 + ((w >> 8) % 8) * 4 + ((w >> 3) % 4));
        if (p < int'(H) && lin < int'(V)) begin
          exp_addr.push_back(lin * int'(H) + p);
          exp_data.push_back(w);
        end
      end
      if (odd) ok = 1'b0;
      if (npix > 0) begin
        if (npix != int'(H) || lin >= int'(V)) ok = 1'b0;
        lin++;
      end
      idx += n;
    end
    exp_ok = ok && (lin == int'(V));
  endtask

  task automatic send_byte(input logic [7:0] b);
    Imagen = b;
    Pclk   = 1'b0;
    repeat (2) @(negedge clk);
    Pclk = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic clear_obs();
    obs_addr.delete();
    obs_data.delete();
    done_cnt  = 0;
    ocup_seen = 1'b0;
  endtask

  // Drives one frame from bq/ln; sim_end makes the last Href fall coincide with the Vsync rise
  task automatic run_frame(input logic [1:0] m, input logic [1:0] m_late,
                           input bit en, input bit sim_end);
    int idx;
    clear_obs();
    modo = m; captura_en = en;
    Vsync = 1'b1; repeat (6) @(negedge clk);
    Vsync = 1'b0; repeat (6) @(negedge clk);
    captura_en = 1'b0; pwdn_req = 1'b0; modo = m_late;
    idx = 0;
    foreach (ln[l]) begin
      Href = 1'b1; repeat (2) @(negedge clk);
      for (int k = 0; k < ln[l]; k++) send_byte(bq[idx+k]);
      idx += ln[l];
      Href = 1'b0;
      if (sim_end && l == ln.size() - 1) Vsync = 1'b1;
      else repeat (4) @(negedge clk);
    end
    Vsync = 1'b1; repeat (6) @(negedge clk);
    Vsync = 1'b0; repeat (6) @(negedge clk);
  endtask

  task automatic check_frame(input string tag);
    check({tag, " nwrites"}, 32'(obs_addr.size()), 32'(exp_addr.size()));
    for (int i = 0; i < exp_addr.size() && i < obs_addr.size(); i++) begin
      check({tag, " addr"}, 32'(obs_addr[i]), 32'(exp_addr[i]));
      check({tag, " data"}, 32'(obs_data[i]), 32'(exp_data[i]));
    end
    check({tag, " done"}, 32'(done_cnt), 32'd1);
    check({tag, " ok"}, 32'(last_ok), 32'(exp_ok));
    check({tag, " ocupado"}, 32'(ocup_seen), 32'd1);
  endtask

  task automatic set_lines(input int nlines, input int len, input logic [7:0] pat[$]);
    bq.delete(); ln.delete();
    for (int l = 0; l < nlines; l++) begin
      ln.push_back(len);
      for (int k = 0; k < len; k++) bq.push_back(pat[k % pat.size()]);
    end
  endtask

  logic [7:0] pat[$];
  int         zeros, toggles;
  logic       prev_x;
  logic [1:0] rm;
  int         nl, nom, len;

  initial begin
    rst = 1'b1; Vsync = 1'b0; Href = 1'b0; Pclk = 1'b0; Imagen = 8'h00;
    modo = 2'b00; captura_en = 1'b0; pwdn_req = 1'b0;
    clear_obs();
    last_ok = 1'b0;
    repeat (3) @(negedge clk);
    check("reset outputs", 32'({Xclk, Reset, PWDN, px_valid, px_addr, px_data,
                                frame_done, frame_ok, ocupado}), 32'd0);

    // Reset release: Reset low 16 cycles, Xclk toggling every cycle
    rst = 1'b0;
    zeros = 0; toggles = 0; prev_x = Xclk;
    for (int k = 0; k < 20; k++) begin
      if (k > 0) @(negedge clk);
      if (!Reset) zeros++;
      if (k > 0 && Xclk != prev_x) toggles++;
      prev_x = Xclk;
    end
    check("reset low cycles", 32'(zeros), 32'd16);
    check("xclk toggles", 32'(toggles), 32'd19);
    check("idle outputs", 32'({PWDN, px_valid, frame_done, frame_ok, ocupado}), 32'd0);

    // RGB565, two short lines
    pat = '{8'hAA, 8'hFF, 8'h00, 8'h55};
    set_lines(2, 4, pat);
    model(2'b00);
    run_frame(2'b00, 2'b10, 1'b1, 1'b0);
    check_frame("rgb565 short");
    check("rgb565 first word", 32'(obs_data.size() > 0 ? obs_data[0] : 16'hxxxx), 32'h0000AAFF);

    // Y8 full frame
    pat = '{8'h11, 8'h22, 8'h33, 8'h44};
    set_lines(2, 4, pat);
    model(2'b10);
    run_frame(2'b10, 2'b00, 1'b1, 1'b0);
    check_frame("y8 full");
    check("y8 full ok const", 32'(last_ok), 32'd1);

    // RGB332 conversion
    pat = '{8'hF8, 8'h1F, 8'h07, 8'hE0};
    set_lines(2, 4, pat);
    model(2'b01);
    run_frame(2'b01, 2'b11, 1'b1, 1'b0);
    check_frame("rgb332");
    check("rgb332 e3", 32'(obs_data.size() > 1 ? obs_data[0] : 16'hxxxx), 32'h000000E3);
    check("rgb332 1c", 32'(obs_data.size() > 1 ? obs_data[1] : 16'hxxxx), 32'h0000001C);

    // Y8 line too long
    pat = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
    bq.delete(); ln.delete();
    ln.push_back(5); ln.push_back(4);
    for (int k = 0; k < 9; k++) bq.push_back(pat[k % 5]);
    model(2'b11);
    run_frame(2'b11, 2'b00, 1'b1, 1'b0);
    check_frame("y8 long line");

    // RGB565 odd byte count on second line
    bq.delete(); ln.delete();
    ln.push_back(8); ln.push_back(9);
    for (int k = 0; k < 17; k++) bq.push_back(8'($urandom));
    model(2'b00);
    run_frame(2'b00, 2'b01, 1'b1, 1'b0);
    check_frame("rgb565 odd");

    // Extra line beyond V_LIN
    pat = '{8'h9A, 8'hBC};
    set_lines(3, 4, pat);
    model(2'b10);
    run_frame(2'b10, 2'b10, 1'b1, 1'b0);
    check_frame("extra line");

    // Href fall coinciding with Vsync rise
    pat = '{8'h5A, 8'hA5, 8'h3C, 8'hC3};
    set_lines(2, 4, pat);
    model(2'b10);
    run_frame(2'b10, 2'b00, 1'b1, 1'b1);
    check_frame("href+vsync");

    // Capture disabled
    set_lines(2, 4, pat);
    run_frame(2'b10, 2'b10, 1'b0, 1'b0);
    check("disabled writes", 32'(obs_addr.size()), 32'd0);
    check("disabled ocupado", 32'(ocup_seen), 32'd0);
    check("disabled done", 32'(done_cnt), 32'd0);

    // Power-down blocks frame start
    pwdn_req = 1'b1;
    @(negedge clk);
    check("pwdn latency", 32'(PWDN), 32'd1);
    run_frame(2'b10, 2'b10, 1'b1, 1'b0);
    check("pwdn writes", 32'(obs_addr.size()), 32'd0);
    check("pwdn ocupado", 32'(ocup_seen), 32'd0);
    check("pwdn done", 32'(done_cnt), 32'd0);

    // rst mid-line aborts the frame
    clear_obs();
    modo = 2'b10; captura_en = 1'b1;
    Vsync = 1'b1; repeat (6) @(negedge clk);
    Vsync = 1'b0; repeat (6) @(negedge clk);
    captura_en = 1'b0;
    Href = 1'b1; repeat (2) @(negedge clk);
    send_byte(8'h77); send_byte(8'h88);
    rst = 1'b1; repeat (2) @(negedge clk);
    check("midrst outputs", 32'({Reset, px_valid, px_addr, px_data, frame_done, ocupado}), 32'd0);
    rst = 1'b0; Href = 1'b0; Pclk = 1'b0;
    repeat (30) @(negedge clk);
    check("midrst no done", 32'(done_cnt), 32'd0);
    pat = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
    set_lines(2, 4, pat);
    model(2'b10);
    run_frame(2'b10, 2'b01, 1'b1, 1'b0);
    check_frame("after midrst");

    // Random frames against the model
    for (int f = 0; f < 8; f++) begin
      rm = 2'($urandom_range(0, 3));
      nl = int'($urandom_range(1, 3));
      nom = rm[1] ? int'(H) : 2 * int'(H);
      bq.delete(); ln.delete();
      for (int l = 0; l < nl; l++) begin
        len = ($urandom_range(0, 2) == 0) ? int'($urandom_range(nom - 2, nom + 3)) : nom;
        ln.push_back(len);
        for (int k = 0; k < len; k++) bq.push_back(8'($urandom));
      end
      model(rm);
      run_frame(rm, 2'($urandom_range(0, 3)), 1'b1, bit'($urandom_range(0, 1)));
      check_frame("random");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
